// File: rtl/alu_div_ex_pkg.sv
// Shared definitions for the execute stage: reset polarity, zero word,
// ALU result classes and operation codes.
package alu_div_ex_pkg;

    localparam logic        RstEnable = 1'b1;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
    localparam logic [7:0] EXE_SUB_OP  = 8'b0010_0010;
    localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/alu_div_ex_div.sv
// ex_div: multi-cycle restoring divider for DIV/DIVU with IDLE/BUSY/DONE
// sequencing, divide-by-zero shortcut and flush abort.
module ex_div
    import alu_div_ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    div_state_e        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] quo_r, rem_r, dvsr_r, hi_r, lo_r;
    logic              neg_q_r, neg_r_r;

    logic              a_neg_s, b_neg_s;
    logic [DATA_W-1:0] a_mag_s, b_mag_s, quo_nx_s, rem_nx_s;
    logic [DATA_W:0]   part_s, diff_s;

    // Operand signs and magnitudes as presented in IDLE
    always_comb begin
        a_neg_s = signed_i & dividend_i[DATA_W-1];
        b_neg_s = signed_i & divisor_i[DATA_W-1];
        if (a_neg_s) begin
            a_mag_s = -dividend_i;
        end else begin
            a_mag_s = dividend_i;
        end
        if (b_neg_s) begin
            b_mag_s = -divisor_i;
        end else begin
            b_mag_s = divisor_i;
        end
    end

    // One restoring step: shift next dividend bit into the remainder, subtract if it fits
    always_comb begin
        part_s = {rem_r, quo_r[DATA_W-1]};
        diff_s = part_s - {1'b0, dvsr_r};
        if (diff_s[DATA_W]) begin
            rem_nx_s = part_s[DATA_W-1:0];
            quo_nx_s = {quo_r[DATA_W-2:0], 1'b0};
        end else begin
            rem_nx_s = diff_s[DATA_W-1:0];
            quo_nx_s = {quo_r[DATA_W-2:0], 1'b1};
        end
    end

    // Divider sequencing and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            quo_r   <= '0;
            rem_r   <= '0;
            dvsr_r  <= '0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else if (flush_i) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i && (divisor_i == '0)) begin
                        lo_r    <= '1;
                        hi_r    <= dividend_i;
                        state_r <= DONE;
                    end else if (start_i) begin
                        quo_r   <= a_mag_s;
                        rem_r   <= '0;
                        dvsr_r  <= b_mag_s;
                        neg_q_r <= a_neg_s ^ b_neg_s;
                        neg_r_r <= a_neg_s;
                        cnt_r   <= CNT_W'(DATA_W);
                        state_r <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    quo_r <= quo_nx_s;
                    rem_r <= rem_nx_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                    // Most-negative / -1 falls out naturally: negating 2^(W-1) wraps to itself
                    if (cnt_r == CNT_W'(1)) begin
                        lo_r    <= neg_q_r ? -quo_nx_s : quo_nx_s;
                        hi_r    <= neg_r_r ? -rem_nx_s : rem_nx_s;
                        state_r <= DONE;
                    end else begin
                        state_r <= BUSY;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Hold request and result strobe, both suppressed by reset and flush
    always_comb begin
        if ((rst == RstEnable) || flush_i) begin
            stall_o = 1'b0;
            done_o  = 1'b0;
        end else begin
            stall_o = (state_r == BUSY) || ((state_r == IDLE) && start_i);
            done_o  = (state_r == DONE);
        end
    end

    assign hi_o = hi_r;
    assign lo_o = lo_r;

endmodule

// File: rtl/alu_div_ex.sv
// alu_div_ex: execute stage with single-cycle ALU and optional multi-cycle
// divider, enabled by defining EX_DIV_EN.
module alu_div_ex
    import alu_div_ex_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REGADDR_W = 5,
    parameter int ALUOP_W   = 8,
    parameter int ALUSEL_W  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ALUSEL_W-1:0]  alusel_i,
    input  logic [ALUOP_W-1:0]   aluop_i,
    input  logic [DATA_W-1:0]    reg1_i,
    input  logic [DATA_W-1:0]    reg2_i,
    input  logic [REGADDR_W-1:0] wd_i,
    input  logic                 wreg_i,
    input  logic                 flush_i,
    output logic [REGADDR_W-1:0] wd_o,
    output logic                 wreg_o,
    output logic [DATA_W-1:0]    wdata_o,
    output logic [DATA_W-1:0]    hi_o,
    output logic [DATA_W-1:0]    lo_o,
    output logic                 whilo_o,
    output logic                 stallreq_o
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0]     sh_amt_s;
    logic [DATA_W-1:0]   alu_res_s;
    logic [ALUSEL_W-1:0] op_cls_s;
    logic                op_known_s, alu_hit_s, div_req_s, div_signed_s;

    assign sh_amt_s  = reg2_i[SH_W-1:0];
    // A single-cycle op only counts when its class field agrees with the opcode
    assign alu_hit_s = op_known_s && (alusel_i == op_cls_s);

    // Single-cycle result and opcode classification
    always_comb begin
        alu_res_s    = '0;
        op_cls_s     = ALUSEL_W'(EXE_RES_NOP);
        op_known_s   = 1'b0;
        div_req_s    = 1'b0;
        div_signed_s = 1'b0;
        case (aluop_i)
            EXE_OR_OP:   begin alu_res_s = reg1_i | reg2_i;    op_cls_s = ALUSEL_W'(EXE_RES_LOGIC); op_known_s = 1'b1; end
            EXE_AND_OP:  begin alu_res_s = reg1_i & reg2_i;    op_cls_s = ALUSEL_W'(EXE_RES_LOGIC); op_known_s = 1'b1; end
            EXE_XOR_OP:  begin alu_res_s = reg1_i ^ reg2_i;    op_cls_s = ALUSEL_W'(EXE_RES_LOGIC); op_known_s = 1'b1; end
            EXE_NOR_OP:  begin alu_res_s = ~(reg1_i | reg2_i); op_cls_s = ALUSEL_W'(EXE_RES_LOGIC); op_known_s = 1'b1; end
            EXE_SLL_OP:  begin alu_res_s = reg1_i << sh_amt_s; op_cls_s = ALUSEL_W'(EXE_RES_SHIFT); op_known_s = 1'b1; end
            EXE_SRL_OP:  begin alu_res_s = reg1_i >> sh_amt_s; op_cls_s = ALUSEL_W'(EXE_RES_SHIFT); op_known_s = 1'b1; end
            EXE_SRA_OP:  begin alu_res_s = $signed(reg1_i) >>> sh_amt_s; op_cls_s = ALUSEL_W'(EXE_RES_SHIFT); op_known_s = 1'b1; end
            EXE_ADD_OP:  begin alu_res_s = reg1_i + reg2_i;    op_cls_s = ALUSEL_W'(EXE_RES_ARITH); op_known_s = 1'b1; end
            EXE_SUB_OP:  begin alu_res_s = reg1_i - reg2_i;    op_cls_s = ALUSEL_W'(EXE_RES_ARITH); op_known_s = 1'b1; end
            EXE_SLT_OP:  begin
                alu_res_s  = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
                op_cls_s   = ALUSEL_W'(EXE_RES_ARITH);
                op_known_s = 1'b1;
            end
            EXE_SLTU_OP: begin
                alu_res_s  = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
                op_cls_s   = ALUSEL_W'(EXE_RES_ARITH);
                op_known_s = 1'b1;
            end
            EXE_DIV_OP:  begin div_req_s = 1'b1; div_signed_s = 1'b1; end
            EXE_DIVU_OP: begin div_req_s = 1'b1; div_signed_s = 1'b0; end
            default:     begin alu_res_s = '0; op_known_s = 1'b0; end
        endcase
    end

    // GPR writeback, cleared while in reset
    always_comb begin
        if (rst == RstEnable) begin
            wd_o    = '0;
            wreg_o  = 1'b0;
            wdata_o = DATA_W'(ZeroWord);
        end else begin
            wd_o    = wd_i;
            wreg_o  = wreg_i & alu_hit_s;
            wdata_o = alu_hit_s ? alu_res_s : '0;
        end
    end

`ifdef EX_DIV_EN
    ex_div #(
        .DATA_W(DATA_W)
    ) u_ex_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_req_s),
        .signed_i   (div_signed_s),
        .flush_i    (flush_i),
        .dividend_i (reg1_i),
        .divisor_i  (reg2_i),
        .stall_o    (stallreq_o),
        .done_o     (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );
`else
    logic unused_s;
    assign unused_s   = &{1'b0, clk, flush_i, div_req_s, div_signed_s};
    assign stallreq_o = 1'b0;
    assign whilo_o    = 1'b0;
    assign hi_o       = '0;
    assign lo_o       = '0;
`endif

endmodule

// File: tb/tb_alu_div_ex.sv
// Randomized self-checking bench for alu_div_ex against an arithmetic
// reference model; divider checks apply when EX_DIV_EN is defined.
module tb_alu_div_ex;
    import alu_div_ex_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   alusel_i;
    logic [7:0]   aluop_i;
    logic [W-1:0] reg1_i, reg2_i;
    logic [4:0]   wd_i;
    logic         wreg_i, flush_i;
    logic [4:0]   wd_o;
    logic         wreg_o, whilo_o, stallreq_o;
    logic [W-1:0] wdata_o, hi_o, lo_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] op_tab  [11];
    logic [2:0] sel_tab [11];

    alu_div_ex dut (
        .clk(clk), .rst(rst), .alusel_i(alusel_i), .aluop_i(aluop_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int     sh;
        longint sa, sb;
        sh = int'(b % W);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            EXE_OR_OP:   ref_alu = a | b;
            EXE_AND_OP:  ref_alu = a & b;
            EXE_XOR_OP:  ref_alu = a ^ b;
            EXE_NOR_OP:  ref_alu = ~(a | b);
            EXE_SLL_OP:  ref_alu = W'(longint'(a) * (longint'(1) << sh));
            EXE_SRL_OP:  ref_alu = a / (W'(1) << sh);
            EXE_SRA_OP:  ref_alu = W'(sa >>> sh);
            EXE_ADD_OP:  ref_alu = W'(longint'(a) + longint'(b));
            EXE_SUB_OP:  ref_alu = W'(longint'(a) - longint'(b));
            EXE_SLT_OP:  ref_alu = (sa < sb) ? 32'd1 : 32'd0;
            EXE_SLTU_OP: ref_alu = (a < b) ? 32'd1 : 32'd0;
            default:     ref_alu = '0;
        endcase
    endfunction

    task automatic alu_case(input logic [2:0] sel, input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [4:0] wd;
        logic       we;
        wd = 5'($urandom);
        we = 1'($urandom);
        @(negedge clk);
        alusel_i = sel; aluop_i = op; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = we;
        #1;
        check_eq("alu_wdata", wdata_o, ref_alu(op, a, b));
        check_eq("alu_wreg", W'(wreg_o), W'(we));
        check_eq("alu_wd", W'(wd_o), W'(wd));
        check_eq("alu_stall", W'(stallreq_o), 32'd0);
        check_eq("alu_whilo", W'(whilo_o), 32'd0);
    endtask

`ifdef EX_DIV_EN
    task automatic ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic div_case(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r;
        int stalls, exp_stalls;
        ref_div(sgn, a, b, q, r);
        exp_stalls = (b == 32'd0) ? 1 : W + 1;
        @(negedge clk);
        alusel_i = EXE_RES_NOP; aluop_i = sgn ? EXE_DIV_OP : EXE_DIVU_OP;
        reg1_i = a; reg2_i = b; wreg_i = 1'b1;
        #1;
        check_eq("div_wreg", W'(wreg_o), 32'd0);
        check_eq("div_wdata", wdata_o, 32'd0);
        stalls = 0;
        while (stallreq_o === 1'b1 && stalls < 3 * W) begin
            check_eq("div_whilo_early", W'(whilo_o), 32'd0);
            stalls++;
            @(negedge clk);
            reg1_i = $urandom; reg2_i = $urandom;
            #1;
        end
        check_eq("div_stalls", W'(stalls), W'(exp_stalls));
        check_eq("div_whilo", W'(whilo_o), 32'd1);
        check_eq("div_lo", lo_o, q);
        check_eq("div_hi", hi_o, r);
        aluop_i = EXE_NOP_OP;
        @(negedge clk);
        #1;
        check_eq("div_whilo_once", W'(whilo_o), 32'd0);
        check_eq("div_stall_after", W'(stallreq_o), 32'd0);
        check_eq("div_lo_hold", lo_o, q);
        check_eq("div_hi_hold", hi_o, r);
    endtask

    task automatic abort_case(input logic use_rst, input int busy_cycles);
        logic [W-1:0] lo_prev, hi_prev;
        int pulses;
        lo_prev = lo_o; hi_prev = hi_o;
        @(negedge clk);
        alusel_i = EXE_RES_NOP; aluop_i = EXE_DIVU_OP; reg1_i = 32'd1000; reg2_i = 32'd3;
        repeat (busy_cycles) @(negedge clk);
        if (use_rst) rst = 1'b1;
        else flush_i = 1'b1;
        #1;
        check_eq("abort_stall", W'(stallreq_o), 32'd0);
        check_eq("abort_whilo", W'(whilo_o), 32'd0);
        check_eq("abort_lo", lo_o, use_rst ? 32'd0 : lo_prev);
        check_eq("abort_hi", hi_o, use_rst ? 32'd0 : hi_prev);
        @(negedge clk);
        rst = 1'b0; flush_i = 1'b0; aluop_i = EXE_NOP_OP;
        #1;
        check_eq("abort_stall_next", W'(stallreq_o), 32'd0);
        pulses = 0;
        repeat (W + 4) begin
            @(negedge clk);
            #1;
            pulses += int'(whilo_o) + int'(stallreq_o);
        end
        check_eq("abort_no_strobe", W'(pulses), 32'd0);
    endtask
`endif

    initial begin
        op_tab  = '{EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP,
                    EXE_SRA_OP, EXE_ADD_OP, EXE_SUB_OP, EXE_SLT_OP, EXE_SLTU_OP};
        sel_tab = '{EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_SHIFT,
                    EXE_RES_SHIFT, EXE_RES_SHIFT, EXE_RES_ARITH, EXE_RES_ARITH, EXE_RES_ARITH,
                    EXE_RES_ARITH};

        rst = 1'b1; flush_i = 1'b0; wd_i = 5'd7; wreg_i = 1'b1;
        alusel_i = EXE_RES_LOGIC; aluop_i = EXE_OR_OP; reg1_i = 32'h1234_5678; reg2_i = 32'h0000_00FF;
`ifdef EX_DIV_EN
        alusel_i = EXE_RES_NOP; aluop_i = EXE_DIVU_OP;
`endif
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_wdata", wdata_o, 32'd0);
        check_eq("rst_wreg", W'(wreg_o), 32'd0);
        check_eq("rst_wd", W'(wd_o), 32'd0);
        check_eq("rst_stall", W'(stallreq_o), 32'd0);
        check_eq("rst_whilo", W'(whilo_o), 32'd0);
        check_eq("rst_hi", hi_o, 32'd0);
        check_eq("rst_lo", lo_o, 32'd0);
        aluop_i = EXE_NOP_OP;
        @(negedge clk);
        rst = 1'b0;

        alu_case(EXE_RES_LOGIC, EXE_OR_OP, 32'h0F0F_0000, 32'h0000_F0F0);
        check_eq("or_vector", wdata_o, 32'h0F0F_F0F0);
        alu_case(EXE_RES_SHIFT, EXE_SRA_OP, 32'h8000_0000, 32'd4);
        check_eq("sra_vector", wdata_o, 32'hF800_0000);
        alu_case(EXE_RES_ARITH, EXE_SLT_OP, 32'hFFFF_FFFF, 32'd1);
        check_eq("slt_vector", wdata_o, 32'd1);
        alu_case(EXE_RES_ARITH, EXE_SLTU_OP, 32'hFFFF_FFFF, 32'd1);
        check_eq("sltu_vector", wdata_o, 32'd0);
        alu_case(EXE_RES_ARITH, EXE_ADD_OP, 32'hFFFF_FFFF, 32'd2);
        alu_case(EXE_RES_ARITH, EXE_SUB_OP, 32'd0, 32'd1);
        alu_case(EXE_RES_SHIFT, EXE_SLL_OP, 32'h0000_0001, 32'hFFFF_FFFF);

        for (int i = 0; i < 200; i++) begin
            int k;
            logic [W-1:0] b;
            k = $urandom_range(0, 10);
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
            alu_case(sel_tab[k], op_tab[k], $urandom, b);
        end

        alu_case(EXE_RES_ARITH, 8'hFF, $urandom, $urandom);
        check_eq("unknown_wreg", W'(wreg_o), 32'd0);

`ifdef EX_DIV_EN
        div_case(1'b0, 32'd100, 32'd7);
        check_eq("divu_100_7_lo", lo_o, 32'd14);
        check_eq("divu_100_7_hi", hi_o, 32'd2);
        div_case(1'b1, 32'hFFFF_FFF9, 32'd2);
        check_eq("div_m7_2_lo", lo_o, 32'hFFFF_FFFD);
        check_eq("div_m7_2_hi", hi_o, 32'hFFFF_FFFF);
        div_case(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check_eq("div_minneg_lo", lo_o, 32'h8000_0000);
        check_eq("div_minneg_hi", hi_o, 32'd0);
        div_case(1'b0, 32'd5, 32'd0);
        check_eq("divu_by0_lo", lo_o, 32'hFFFF_FFFF);
        check_eq("divu_by0_hi", hi_o, 32'd5);
        div_case(1'b1, 32'hFFFF_FFF7, 32'd0);
        div_case(1'b0, 32'hFFFF_FFFF, 32'd1);
        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] b;
            b = ($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 1000)) : W'($urandom);
            div_case(1'($urandom), $urandom, b);
        end
        abort_case(1'b0, 10);
        abort_case(1'b1, 20);
        div_case(1'b1, 32'd77, 32'hFFFF_FFF6);
`else
        @(negedge clk);
        alusel_i = EXE_RES_NOP; aluop_i = EXE_DIV_OP; reg1_i = 32'd100; reg2_i = 32'd7; wreg_i = 1'b1;
        repeat (3) begin
            #1;
            check_eq("nodiv_stall", W'(stallreq_o), 32'd0);
            check_eq("nodiv_whilo", W'(whilo_o), 32'd0);
            check_eq("nodiv_wdata", wdata_o, 32'd0);
            check_eq("nodiv_wreg", W'(wreg_o), 32'd0);
            check_eq("nodiv_hi", hi_o, 32'd0);
            check_eq("nodiv_lo", lo_o, 32'd0);
            @(negedge clk);
            aluop_i = EXE_DIVU_OP;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
